// File: rtl/sparc_exu_thrq_pkg.sv
// Shared types and helpers for the EXU per-thread request queue.
package sparc_exu_thrq_pkg;

  localparam int unsigned NTHR  = 4;
  localparam int unsigned TID_W = 2;

  typedef logic [NTHR-1:0] thr_vec_t;

  // Pure OR-encoder; the result is only meaningful for a one-hot input.
  function automatic logic [TID_W-1:0] onehot_enc(thr_vec_t v);
    logic [TID_W-1:0] r;
    r = '0;
    for (int i = 0; i < NTHR; i++) begin
      if (v[i]) r = r | TID_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sparc_exu_thrq_fifo.sv
// Single-thread request FIFO with synchronous flush; full/empty derive from an occupancy count.
module sparc_exu_thrq_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_ok, pop_ok;

  assign full_o  = (cnt_q == OCC_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A full queue refuses the push even when it pops in the same cycle.
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      cnt_d = cnt_q + OCC_W'(1);
      else if (!push_ok && pop_ok) cnt_d = cnt_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/sparc_exu_thrreq_q.sv
// Per-thread request queues feeding the EXU round-robin arbiter and the shared issue port.
// Optional per-thread stall counters are built when SPARC_EXU_THRQ_PERF_EN is defined.
module sparc_exu_thrreq_q
  import sparc_exu_thrq_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic [NTHR-1:0]        enq_vld_i,
  input  logic [NTHR*DATA_W-1:0] enq_data_i,
  output logic [NTHR-1:0]        enq_rdy_o,
  input  logic [NTHR-1:0]        flush_i,
  output logic [NTHR-1:0]        req_vec_o,
  input  logic [NTHR-1:0]        grant_vec_i,
  output logic                   advance_o,
  output logic                   iss_vld_o,
  output logic [TID_W-1:0]       iss_tid_o,
  output logic [DATA_W-1:0]      iss_data_o,
  input  logic                   iss_rdy_i,
  output logic [NTHR*CNT_W-1:0]  stall_cnt_o
);

  thr_vec_t          full, empty, hit, pop;
  logic [DATA_W-1:0] head [NTHR];
  logic              hit_onehot;

  for (genvar t = 0; t < NTHR; t++) begin : g_thr
    sparc_exu_thrq_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .push_i  (enq_vld_i[t]),
      .data_i  (enq_data_i[t*DATA_W +: DATA_W]),
      .pop_i   (pop[t]),
      .flush_i (flush_i[t]),
      .full_o  (full[t]),
      .empty_o (empty[t]),
      .head_o  (head[t])
    );
  end

  assign enq_rdy_o = ~full;
  assign req_vec_o = ~empty & ~flush_i;

  // The arbiter parks grant on thread 0 when idle, so grant is qualified by request.
  assign hit        = grant_vec_i & req_vec_o;
  assign hit_onehot = ((hit & (hit - thr_vec_t'(1))) == '0);
  assign iss_vld_o  = (hit != '0) && hit_onehot;
  assign iss_tid_o  = onehot_enc(hit);
  assign iss_data_o = head[iss_tid_o];
  assign advance_o  = iss_vld_o & iss_rdy_i;
  assign pop        = advance_o ? hit : '0;

  always_ff @(posedge clk_i) begin
    if (arst_ni) begin
      assert (hit_onehot) else $error("sparc_exu_thrreq_q: multi-bit grant hit %b", hit);
    end
  end

`ifdef SPARC_EXU_THRQ_PERF_EN
  logic [CNT_W-1:0] stall_q [NTHR];
  logic [CNT_W-1:0] stall_d [NTHR];

  always_comb begin
    stall_cnt_o = '0;
    for (int t = 0; t < NTHR; t++) begin
      stall_d[t] = stall_q[t];
      if (req_vec_o[t] && !pop[t] && !(&stall_q[t])) stall_d[t] = stall_q[t] + CNT_W'(1);
      stall_cnt_o[t*CNT_W +: CNT_W] = stall_q[t];
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int t = 0; t < NTHR; t++) stall_q[t] <= '0;
    end else begin
      for (int t = 0; t < NTHR; t++) stall_q[t] <= stall_d[t];
    end
  end
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sparc_exu_thrreq_q.sv
// Directed bench for sparc_exu_thrreq_q (DATA_W=8, DEPTH=2, CNT_W=2).
module tb_sparc_exu_thrreq_q;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 2;

  logic          clk_i = 1'b0;
  logic          arst_ni;
  logic [3:0]    enq_vld;
  logic [4*DW-1:0] enq_data;
  logic [3:0]    enq_rdy;
  logic [3:0]    flush;
  logic [3:0]    req_vec;
  logic [3:0]    grant_vec;
  logic          advance;
  logic          iss_vld;
  logic [1:0]    iss_tid;
  logic [DW-1:0] iss_data;
  logic          iss_rdy;
  logic [4*CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  sparc_exu_thrreq_q #(
    .DATA_W (DW),
    .DEPTH  (2),
    .CNT_W  (CW)
  ) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .enq_vld_i   (enq_vld),
    .enq_data_i  (enq_data),
    .enq_rdy_o   (enq_rdy),
    .flush_i     (flush),
    .req_vec_o   (req_vec),
    .grant_vec_i (grant_vec),
    .advance_o   (advance),
    .iss_vld_o   (iss_vld),
    .iss_tid_o   (iss_tid),
    .iss_data_o  (iss_data),
    .iss_rdy_i   (iss_rdy),
    .stall_cnt_o (stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_vec"}, 64'(req_vec), 64'h0);
    check({tag, " iss_vld"}, 64'(iss_vld), 64'h0);
    check({tag, " advance"}, 64'(advance), 64'h0);
    check({tag, " enq_rdy"}, 64'(enq_rdy), 64'hF);
    check({tag, " stall_cnt"}, 64'(stall_cnt), 64'h0);
  endtask

  initial begin
    arst_ni = 1'b0; enq_vld = '0; enq_data = '0; flush = '0; grant_vec = '0; iss_rdy = 1'b0;
    #1;
    check_reset_outputs("reset");
    #11 arst_ni = 1'b1;

    // 1: single enqueue/issue on thread 2
    enq_vld = 4'b0100; enq_data[2*DW +: DW] = 8'hA5;
    #1 check("t1 req_vec same cycle", 64'(req_vec), 64'h0);
    step();
    enq_vld = '0;
    check("t1 req_vec", 64'(req_vec), 64'h4);
    grant_vec = 4'b0100; iss_rdy = 1'b1;
    #1;
    check("t1 iss_vld", 64'(iss_vld), 64'h1);
    check("t1 iss_tid", 64'(iss_tid), 64'h2);
    check("t1 iss_data", 64'(iss_data), 64'hA5);
    check("t1 advance", 64'(advance), 64'h1);
    step();
    grant_vec = '0;
    #1 check("t1 req_vec after", 64'(req_vec), 64'h0);

    // 2: idle arbiter parks grant on thread 0
    grant_vec = 4'b0001; iss_rdy = 1'b1;
    #1;
    check("t2 iss_vld", 64'(iss_vld), 64'h0);
    check("t2 advance", 64'(advance), 64'h0);
    step();
    check("t2 enq_rdy", 64'(enq_rdy), 64'hF);

    // 3: fill thread 0, enq+pop when full, then enq+pop when not full across wrap
    grant_vec = '0;
    enq_vld = 4'b0001; enq_data[0 +: DW] = 8'h11;
    step();
    enq_data[0 +: DW] = 8'h22;
    step();
    enq_vld = '0;
    check("t3 enq_rdy full", 64'(enq_rdy), 64'hE);
    enq_vld = 4'b0001; enq_data[0 +: DW] = 8'h33; grant_vec = 4'b0001;
    #1 check("t3 head0", 64'(iss_data), 64'h11);
    check("t3 advance full", 64'(advance), 64'h1);
    step();
    check("t3 enq_rdy one left", 64'(enq_rdy), 64'hF);
    enq_data[0 +: DW] = 8'h44;
    #1 check("t3 head1", 64'(iss_data), 64'h22);
    step();
    enq_vld = '0;
    check("t3 req after enq+pop", 64'(req_vec), 64'h1);
    check("t3 head wrapped", 64'(iss_data), 64'h44);
    step();
    grant_vec = '0;
    #1 check("t3 drained", 64'(req_vec), 64'h0);

    // 4: back-pressure on thread 3
    enq_vld = 4'b1000; enq_data[3*DW +: DW] = 8'h5A;
    step();
    enq_data[3*DW +: DW] = 8'h6B;
    step();
    enq_vld = '0; grant_vec = 4'b1000; iss_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4 iss_vld held", 64'(iss_vld), 64'h1);
      check("t4 iss_data stable", 64'(iss_data), 64'h5A);
      check("t4 advance low", 64'(advance), 64'h0);
      step();
    end
    iss_rdy = 1'b1;
    #1 check("t4 advance", 64'(advance), 64'h1);
    step();
    iss_rdy = 1'b0;
    #1;
    check("t4 single pop data", 64'(iss_data), 64'h6B);
    check("t4 single pop req", 64'(req_vec), 64'h8);
    grant_vec = '0;

    // 5: flush thread 1 with a colliding enqueue (thread 3 still holds 6B)
    enq_vld = 4'b0010; enq_data[1*DW +: DW] = 8'h71;
    step();
    enq_data[1*DW +: DW] = 8'h72;
    step();
    check("t5 full", 64'(enq_rdy), 64'hD);
    flush = 4'b0010; enq_data[1*DW +: DW] = 8'h73;
    #1 check("t5 req masked", 64'(req_vec), 64'h8);
    step();
    flush = '0; enq_vld = '0;
    #1;
    check("t5 empty after flush", 64'(req_vec), 64'h8);
    check("t5 enq_rdy", 64'(enq_rdy), 64'hF);
    grant_vec = 4'b1000; iss_rdy = 1'b1;
    step();
    grant_vec = '0; iss_rdy = 1'b0;
    #1 check("t5 clean", 64'(req_vec), 64'h0);

    // 6: stall counting on thread 3, then reset mid-stall
    arst_ni = 1'b0;
    #1 check_reset_outputs("t6 pre reset");
    arst_ni = 1'b1;
    enq_vld = 4'b1000; enq_data[3*DW +: DW] = 8'h3C;
    step();
    enq_vld = '0; grant_vec = 4'b1000; iss_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
`ifdef SPARC_EXU_THRQ_PERF_EN
      check("t6 stall_cnt3", 64'(stall_cnt[3*CW +: CW]), (i > 3) ? 64'd3 : 64'(i));
`else
      check("t6 stall_cnt off", 64'(stall_cnt), 64'h0);
`endif
    end
    check("t6 iss_vld before reset", 64'(iss_vld), 64'h1);
    #2 arst_ni = 1'b0;
    #1 check_reset_outputs("t6 mid reset");
    step();
    arst_ni = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
